// File: rtl/alu_seq_cc.sv
// alu_seq_cc: registered execute-stage ALU with valid/ready handshake, iterative signed multiply and condition codes
module alu_seq_cc #(
    parameter int W          = 64,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic         set_cc,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         err,
    output logic         zf,
    output logic         sf,
    output logic         of
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;
    state_t         r_state, w_state_nx;
    logic [W-1:0]   r_result;
    logic           r_err, r_zf, r_sf, r_of;
    logic [2*W-1:0] r_acc, r_mc, w_acc_nx, w_prod;
    logic [W-1:0]   r_mp, w_a_mag, w_b_mag, w_alu_res, w_mul_res;
    logic           r_neg, r_set_cc;
    logic [CW-1:0]  r_cnt;
    logic           w_accept, w_is_mul, w_is_alu, w_alu_of, w_mul_of, w_mul_done;
    assign in_ready  = r_state == IDLE || (r_state == DONE && out_ready);
    assign out_valid = r_state == DONE;
    assign result    = r_result;
    assign err       = r_err;
    assign zf        = r_zf;
    assign sf        = r_sf;
    assign of        = r_of;
    always_comb begin
        w_accept   = in_valid && in_ready;
        w_is_mul   = ENABLE_MUL && op == 3'd4;
        w_is_alu   = !op[2];
        w_alu_res  = op == 3'd0 ? b + a : op == 3'd1 ? b - a : op == 3'd2 ? a & b : a ^ b;
        w_alu_of   = op == 3'd0 ? (a[W-1] == b[W-1]) && (w_alu_res[W-1] != a[W-1]) :
                     op == 3'd1 ? (a[W-1] != b[W-1]) && (w_alu_res[W-1] != b[W-1]) : 1'b0;
        w_a_mag    = a[W-1] ? -a : a;
        w_b_mag    = b[W-1] ? -b : b;
        w_acc_nx   = r_acc + (r_mp[0] ? r_mc : '0);
        w_prod     = r_neg ? -w_acc_nx : w_acc_nx;
        w_mul_res  = w_prod[W-1:0];
        w_mul_of   = w_prod[2*W-1:W] != {W{w_prod[W-1]}};
        w_mul_done = r_state == MUL_BUSY && r_cnt == '0;
        w_state_nx = w_accept ? (w_is_mul ? MUL_BUSY : DONE) :
                     w_mul_done ? DONE :
                     (r_state == DONE && out_ready) ? IDLE : r_state;
    end
    // Bit 0 of the multiplier is consumed at acceptance so the last of W bits lands on edge W
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_err    <= 1'b0;
            r_zf     <= 1'b1;
            r_sf     <= 1'b0;
            r_of     <= 1'b0;
            r_acc    <= '0;
            r_mc     <= '0;
            r_mp     <= '0;
            r_neg    <= 1'b0;
            r_set_cc <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept && w_is_mul) begin
                r_acc    <= w_b_mag[0] ? {{W{1'b0}}, w_a_mag} : '0;
                r_mc     <= {{(W-1){1'b0}}, w_a_mag, 1'b0};
                r_mp     <= w_b_mag >> 1;
                r_neg    <= a[W-1] ^ b[W-1];
                r_set_cc <= set_cc;
                r_cnt    <= CW'(W-2);
            end else if (r_state == MUL_BUSY) begin
                r_acc <= w_acc_nx;
                r_mc  <= r_mc << 1;
                r_mp  <= r_mp >> 1;
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_accept && !w_is_mul) begin
                r_result <= w_is_alu ? w_alu_res : '0;
                r_err    <= !w_is_alu;
                if (w_is_alu && set_cc) begin
                    r_zf <= w_alu_res == '0;
                    r_sf <= w_alu_res[W-1];
                    r_of <= w_alu_of;
                end
            end else if (w_mul_done) begin
                r_result <= w_mul_res;
                r_err    <= 1'b0;
                if (r_set_cc) begin
                    r_zf <= w_mul_res == '0;
                    r_sf <= w_mul_res[W-1];
                    r_of <= w_mul_of;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_cc.sv
// tb_alu_seq_cc: directed and randomized checks of alu_seq_cc against a transaction-level reference model
module tb_alu_seq_cc;
    localparam int W = 64;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    logic         in_valid = 1'b0, in_ready, set_cc = 1'b0, out_valid, out_ready = 1'b1, err, zf, sf, of;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0, b = '0, result;
    logic         v2 = 1'b0, rdy2, cc2 = 1'b0, ov2, err2, zf2, sf2, of2;
    logic [2:0]   op2 = 3'd0;
    logic [7:0]   a2 = '0, b2 = '0, res2;
    alu_seq_cc #(.W(W), .ENABLE_MUL(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .set_cc(set_cc),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err),
        .zf(zf), .sf(sf), .of(of)
    );
    alu_seq_cc #(.W(8), .ENABLE_MUL(1'b0)) dut_nomul (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .op(op2), .set_cc(cc2),
        .a(a2), .b(b2), .out_valid(ov2), .out_ready(1'b1), .result(res2), .err(err2),
        .zf(zf2), .sf(sf2), .of(of2)
    );
    int checks = 0;
    int errors = 0;
    logic         m_init = 1'b0, m_valid = 1'b0, m_pending = 1'b0, m_err = 1'b0;
    logic         m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0, m_in_ready;
    logic [W-1:0] m_result = '0, p_result = '0;
    logic         p_of = 1'b0, p_cc = 1'b0;
    int           p_left = 0;
    always_comb m_in_ready = !m_pending && (!m_valid || out_ready);
    // Plain-arithmetic reference: widened sums for overflow, full signed product for MUL
    function automatic void model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] r, output logic ov, output logic ok);
        logic signed [W:0]     s;
        logic signed [2*W-1:0] p;
        s = '0; p = '0; r = '0; ov = 1'b0; ok = 1'b1;
        case (o)
            3'd0: begin s = $signed({y[W-1], y}) + $signed({x[W-1], x}); r = s[W-1:0]; ov = s[W] != s[W-1]; end
            3'd1: begin s = $signed({y[W-1], y}) - $signed({x[W-1], x}); r = s[W-1:0]; ov = s[W] != s[W-1]; end
            3'd2: r = x & y;
            3'd3: r = x ^ y;
            3'd4: begin p = $signed(x) * $signed(y); r = p[W-1:0]; ov = p != {{W{r[W-1]}}, r}; end
            default: ok = 1'b0;
        endcase
    endfunction
    initial forever begin
        logic         acc, ov, ok;
        logic [W-1:0] r;
        @(posedge clk);
        if (rst) begin
            m_init = 1'b1; m_valid = 1'b0; m_pending = 1'b0; m_result = '0; m_err = 1'b0;
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        end else if (m_init) begin
            acc = in_valid && !m_pending && (!m_valid || out_ready);
            if (m_pending) begin
                p_left--;
                if (p_left == 0) begin
                    m_pending = 1'b0; m_valid = 1'b1; m_result = p_result; m_err = 1'b0;
                    if (p_cc) begin m_zf = p_result == '0; m_sf = p_result[W-1]; m_of = p_of; end
                end
            end else if (m_valid && out_ready) m_valid = 1'b0;
            if (acc) begin
                model_op(op, a, b, r, ov, ok);
                if (op == 3'd4) begin
                    m_pending = 1'b1; p_left = W - 1; p_result = r; p_of = ov; p_cc = set_cc;
                end else begin
                    m_valid = 1'b1; m_result = r; m_err = !ok;
                    if (ok && set_cc) begin m_zf = r == '0; m_sf = r[W-1]; m_of = ov; end
                end
            end
        end
    end
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask
    task automatic lit(input string name, input logic [W-1:0] dut_v, input logic [W-1:0] model_v, input logic [W-1:0] expv);
        chk({name, ".dut"}, dut_v, expv);
        chk({name, ".model"}, model_v, expv);
    endtask
    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk("cmp.in_ready", W'(in_ready), W'(m_in_ready));
            chk("cmp.out_valid", W'(out_valid), W'(m_valid));
            chk("cmp.zf", W'(zf), W'(m_zf));
            chk("cmp.sf", W'(sf), W'(m_sf));
            chk("cmp.of", W'(of), W'(m_of));
            if (m_valid) begin
                chk("cmp.result", result, m_result);
                chk("cmp.err", W'(err), W'(m_err));
            end
        end
    end
    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic cc, input logic ordy);
        int n;
        @(posedge clk); #1;
        op = o; a = x; b = y; set_cc = cc; out_ready = ordy; in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_in_ready && n < 300);
        chk("send.accept_bound", W'(m_in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom}; set_cc = 1'($urandom);
    endtask
    task automatic mul_wait(input string name);
        int n, busy_rdy;
        n = 0; busy_rdy = 0;
        do begin
            @(negedge clk); n++;
            if (!out_valid && in_ready) busy_rdy++;
        end while (!out_valid && n < 200);
        chk({name, ".latency"}, W'(n), W'(W));
        chk({name, ".busy_ready"}, W'(busy_rdy), W'(0));
    endtask
    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {1'b1, {(W-1){1'b0}}};
            2: return '1;
            3: return {1'b0, {(W-1){1'b1}}};
            4: return W'($urandom_range(0, 40)) - W'(20);
            default: return {$urandom, $urandom};
        endcase
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
    initial begin
        int seen, r;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        lit("reset.in_ready", W'(in_ready), W'(m_in_ready), W'(1));
        lit("reset.out_valid", W'(out_valid), W'(m_valid), W'(0));
        lit("reset.result", result, m_result, '0);
        lit("reset.err", W'(err), W'(m_err), W'(0));
        lit("reset.zf", W'(zf), W'(m_zf), W'(1));
        lit("reset.sf_of", W'({sf, of}), W'({m_sf, m_of}), W'(0));
        send(3'd0, 64'd5, 64'd7, 1'b1, 1'b1);
        @(negedge clk);
        lit("add.valid", W'(out_valid), W'(m_valid), W'(1));
        lit("add.result", result, m_result, 64'd12);
        lit("add.flags", W'({err, zf, sf, of}), W'({m_err, m_zf, m_sf, m_of}), W'(0));
        send(3'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
        @(negedge clk);
        lit("sub.result", result, m_result, 64'h7FFF_FFFF_FFFF_FFFF);
        lit("sub.zf_sf_of", W'({zf, sf, of}), W'({m_zf, m_sf, m_of}), W'(3'b001));
        send(3'd3, 64'hDEAD, 64'hDEAD, 1'b0, 1'b1);
        @(negedge clk);
        lit("xor.result", result, m_result, '0);
        lit("xor.cc_kept", W'({zf, sf, of}), W'({m_zf, m_sf, m_of}), W'(3'b001));
        send(3'd4, -64'sd3, 64'd7, 1'b1, 1'b1);
        mul_wait("mul1");
        lit("mul1.result", result, m_result, 64'hFFFF_FFFF_FFFF_FFEB);
        lit("mul1.zf_sf_of", W'({zf, sf, of}), W'({m_zf, m_sf, m_of}), W'(3'b010));
        send(3'd4, 64'h1_0000_0000, 64'h1_0000_0000, 1'b1, 1'b1);
        mul_wait("mul2");
        lit("mul2.result", result, m_result, '0);
        lit("mul2.zf_sf_of", W'({zf, sf, of}), W'({m_zf, m_sf, m_of}), W'(3'b101));
        send(3'd6, 64'd5, 64'd9, 1'b1, 1'b1);
        @(negedge clk);
        lit("ill.result", result, m_result, '0);
        lit("ill.err", W'(err), W'(m_err), W'(1));
        lit("ill.cc_kept", W'({zf, sf, of}), W'({m_zf, m_sf, m_of}), W'(3'b101));
        send(3'd2, 64'hF0F0, 64'hFF00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            lit("hold.result", result, m_result, 64'hF000);
            lit("hold.valid_ready", W'({out_valid, in_ready}), W'({m_valid, m_in_ready}), W'(2'b10));
            lit("hold.cc", W'({zf, sf, of}), W'({m_zf, m_sf, m_of}), W'(0));
        end
        send(3'd0, 64'd1, 64'd1, 1'b1, 1'b1);
        @(negedge clk);
        lit("b2b.result", result, m_result, 64'd2);
        lit("b2b.valid", W'(out_valid), W'(m_valid), W'(1));
        @(posedge clk); #1;
        v2 = 1'b1; op2 = 3'd4; a2 = 8'd3; b2 = 8'd5; cc2 = 1'b1;
        @(negedge clk);
        chk("nomul.in_ready", W'(rdy2), W'(1));
        @(posedge clk); #1 v2 = 1'b0;
        @(negedge clk);
        chk("nomul.valid", W'(ov2), W'(1));
        chk("nomul.err", W'(err2), W'(1));
        chk("nomul.result", W'(res2), W'(0));
        chk("nomul.cc_kept", W'({zf2, sf2, of2}), W'(3'b100));
        send(3'd4, 64'd5, 64'd9, 1'b1, 1'b1);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        lit("rstmul.valid", W'(out_valid), W'(m_valid), W'(0));
        lit("rstmul.in_ready", W'(in_ready), W'(m_in_ready), W'(1));
        lit("rstmul.cc", W'({zf, sf, of}), W'({m_zf, m_sf, m_of}), W'(3'b100));
        seen = 0;
        repeat (80) begin @(negedge clk); if (out_valid) seen++; end
        chk("rstmul.never_valid", W'(seen), W'(0));
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst = $urandom_range(0, 299) == 0;
            in_valid = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 15);
            op = r < 10 ? 3'(r % 4) : r < 13 ? 3'd4 : 3'(5 + r % 3);
            a = pick(); b = pick();
            set_cc = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk); #1 in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
